// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: multi-cycle adder that sums two WIDTH-bit operands plus a
// carry-in CHUNK bits per clock. The carry between chunks is held in a register.
// The handshake is start/busy/done. Results are held on sum/cout/ovf until the next done.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset; aborts any operation in flight
//   start  - request, sampled only while idle
//   a, b   - operands, captured on the accepting edge
//   cin    - carry-in, captured on the accepting edge
//   sub    - (only with SERIAL_ADDER_SUB_EN) 1 = compute a - b, captured with operands
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse, result valid
//   sum    - result modulo 2^WIDTH
//   cout   - carry out of the MSB (no-borrow flag when subtracting)
//   ovf    - two's-complement signed overflow
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input (a + ~b + 1).

module serial_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [WIDTH-1:0]  b_in_c;
    logic              cin_in_c;
    logic [CHUNK:0]    chunk_res_c;

    // Operand B and initial carry as latched: subtraction folds into a + ~b + 1
`ifdef SERIAL_ADDER_SUB_EN
    assign b_in_c   = sub ? ~b : b;
    assign cin_in_c = sub ? 1'b1 : cin;
`else
    assign b_in_c   = b;
    assign cin_in_c = cin;
`endif

    // Narrow adder always works on the low chunk; a_q/b_q shift right each RUN cycle
    assign chunk_res_c = (CHUNK+1)'(a_q[CHUNK-1:0])
                       + (CHUNK+1)'(b_q[CHUNK-1:0])
                       + (CHUNK+1)'(carry_q);

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_in_c;
                    carry_d = cin_in_c;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b_in_c[WIDTH-1];
                    work_d  = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_res_c[CHUNK];
                // New chunk enters at the top; after NCHUNK steps chunk 0 sits at the bottom
                work_d  = (work_q >> CHUNK)
                        | (WIDTH'(chunk_res_c[CHUNK-1:0]) << (WIDTH - CHUNK));
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NCHUNK - 1)) begin
                    sum_d   = work_d;
                    cout_d  = chunk_res_c[CHUNK];
                    ovf_d   = (a_msb_q == b_msb_q) && (work_d[WIDTH-1] != a_msb_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Testbench for serial_chunk_adder: scoreboard of expected results checked by a
// negedge monitor whenever done is presented.
module tb_serial_chunk_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               cyc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    serial_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain wide arithmetic on the whole operands
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic s, input int c);
        exp_t             r;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] yy;
        logic             cc;
        yy     = s ? ~y : y;
        cc     = s ? 1'b1 : ci;
        full   = {1'b0, x} + {1'b0, yy} + (WIDTH+1)'(cc);
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        r.cyc  = c;
        return r;
    endfunction

    task automatic post(input string name, input logic [31:0] act, input logic [31:0] expv);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = expv;
        chk_q.push_back(c);
    endtask

    // Monitor: drains direct checks and compares every done against the scoreboard
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            tests++;
            if (c.act !== c.exp) begin
                fails++;
                $display("FAIL %s: got %h, expected %h", c.name, c.act, c.exp);
            end
        end
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d with sum=%h, expected none", cyc, sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                tests += 5;
                if (sum !== e.sum) begin
                    fails++; $display("FAIL sum: got %h, expected %h", sum, e.sum);
                end
                if (cout !== e.cout) begin
                    fails++; $display("FAIL cout: got %b, expected %b (sum %h)", cout, e.cout, e.sum);
                end
                if (ovf !== e.ovf) begin
                    fails++; $display("FAIL ovf: got %b, expected %b (sum %h)", ovf, e.ovf, e.sum);
                end
                if (cyc != e.cyc) begin
                    fails++; $display("FAIL done_cycle: got %0d, expected %0d", cyc, e.cyc);
                end
                if (busy !== 1'b0) begin
                    fails++; $display("FAIL busy_at_done: got %b, expected 0", busy);
                end
            end
        end
    end

    // Issue one operation: wait for idle, present start for one edge
    task automatic op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                      input logic tc, input logic ts);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) post("idle_timeout", 32'(busy), 32'd0);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        sub   = ts;
        start = 1'b1;
        exp_q.push_back(model(ta, tb_v, tc, ts, cyc + 1 + NCHUNK));
        @(posedge clk);
        #1;
        start = 1'b0;
        post("busy_after_accept", 32'(busy), 32'd1);
        // Operands scrambled after acceptance must not matter
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return WIDTH'(16'h8000);
            3:       return WIDTH'(16'h7FFF);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        post("reset_busy", 32'(busy), 32'd0);
        post("reset_done", 32'(done), 32'd0);
        post("reset_sum",  32'(sum),  32'd0);
        post("reset_cout", 32'(cout), 32'd0);
        post("reset_ovf",  32'(ovf),  32'd0);

        op(16'h1234, 16'h4321, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op(16'h000F, 16'h0000, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op(16'h8000, 16'h8000, 1'b0, 1'b0);

        // start while busy is ignored; start in the done cycle is accepted
        op(16'h0001, 16'h0001, 1'b0, 1'b0);
        begin
            int n;
            @(negedge clk);
            @(negedge clk);
            a = 16'h00FF; b = 16'h00FF; cin = 1'b0; sub = 1'b0; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n = 0;
            @(negedge clk);
            while (!done && n < 50) begin
                @(negedge clk);
                n++;
            end
            post("done_seen", 32'(done), 32'd1);
            a = 16'h00FF; b = 16'h00FF; cin = 1'b0; sub = 1'b0; start = 1'b1;
            exp_q.push_back(model(16'h00FF, 16'h00FF, 1'b0, 1'b0, cyc + 1 + NCHUNK));
            @(posedge clk);
            #1;
            start = 1'b0;
            post("busy_b2b", 32'(busy), 32'd1);
        end

        // Reset after two RUN cycles aborts the operation
        op(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        post("abort_sum",  32'(sum),  32'd0);
        post("abort_busy", 32'(busy), 32'd0);
        post("abort_done", 32'(done), 32'd0);
        post("abort_cout", 32'(cout), 32'd0);
        repeat (8) @(negedge clk);
        op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        op(16'h0005, 16'h0007, 1'b0, 1'b1);
        op(16'h0007, 16'h0005, 1'b0, 1'b1);
        op(16'h8000, 16'h0001, 1'b1, 1'b1);
        op(16'h0005, 16'h0007, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            logic s;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            op(pick(), pick(), 1'($urandom), s);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        begin
            int n;
            n = 0;
            while (exp_q.size() > 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            post("drain_pending", 32'(exp_q.size()), 32'd0);
        end
        repeat (3) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
